// File: rtl/stall_ctrl_pkg.sv
// Shared stall bus definitions: bus width, per-bit Stop/NoStop levels, the
// three source patterns and the multi-cycle sequencer states.
package stall_ctrl_pkg;

    localparam int STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Every pattern is a contiguous run of Stop starting at the PC bit.
    localparam stall_bus_t LU_PAT = 6'b000111;
    localparam stall_bus_t MC_PAT = 6'b001111;
    localparam stall_bus_t MW_PAT = 6'b011111;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MC  = 1'b1
    } mc_state_t;

endpackage

// File: rtl/stall_ctrl_mc_counter.sv
// Multi-cycle occupancy countdown: loads len-1, decrements while enabled.
// Latency: last is combinational from the count register.
// Backpressure: none; the count runs regardless of other stall sources.
module stall_ctrl_mc_counter #(
    parameter int MC_LEN_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [MC_LEN_W-1:0] len,
    input  logic                dec,
    output logic                last
);

    logic [MC_LEN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len - MC_LEN_W'(1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - MC_LEN_W'(1);
        end
    end

    assign last = (cnt == MC_LEN_W'(1));

endmodule

// File: rtl/stall_ctrl.sv
// Merges load-use, multi-cycle and memory-wait stall requests into the stall bus.
// Latency: stall is combinational (zero cycles); mc_busy/mc_done/counters registered.
// Backpressure: highest source wins (MW > MC > LU); the MC countdown never pauses.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MC_LEN_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                stallreq_mem,
    output stall_bus_t          stall,
    output logic                mc_busy,
    output logic                mc_done,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    loaduse_cnt
);

    mc_state_t state, state_nxt;
    logic      mc_load;
    logic      mc_last;
    logic      mc_act;
    logic      mc_done_nxt;
    logic      lu_win;

    stall_ctrl_mc_counter #(
        .MC_LEN_W (MC_LEN_W)
    ) u_mc_counter (
        .clk  (clk),
        .rst  (rst),
        .load (mc_load),
        .len  (ex_mc_len),
        .dec  (state == ST_MC),
        .last (mc_last)
    );

    always_comb begin
        state_nxt   = state;
        mc_load     = 1'b0;
        mc_act      = 1'b0;
        mc_done_nxt = 1'b0;
        case (state)
            ST_RUN: begin
                // len 0/1 never stalls; len 1 still completes next cycle
                if (ex_mc_start) begin
                    if (ex_mc_len >= MC_LEN_W'(2)) begin
                        mc_load   = 1'b1;
                        mc_act    = 1'b1;
                        state_nxt = ST_MC;
                    end else if (ex_mc_len == MC_LEN_W'(1)) begin
                        mc_done_nxt = 1'b1;
                    end
                end
            end
            ST_MC: begin
                mc_act = 1'b1;
                if (mc_last) begin
                    state_nxt   = ST_RUN;
                    mc_done_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        stall  = '0;
        lu_win = 1'b0;
        if (stallreq_mem) begin
            stall = MW_PAT;
        end else if (mc_act) begin
            stall = MC_PAT;
        end else if (stallreq_id) begin
            stall  = LU_PAT;
            lu_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            mc_done      <= 1'b0;
            stall_cycles <= '0;
            loaduse_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            mc_done <= mc_done_nxt;
            if (stall[0] == STOP) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (lu_win) begin
                loaduse_cnt <= loaduse_cnt + CNT_W'(1);
            end
        end
    end

    assign mc_busy = (state == ST_MC);

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall controller for the five-stage MIPS core. It merges stall requests from ID (load-use), EX (multi-cycle ops: mult/div) and MEM (data SRAM not ready) into the shared `StallBus` vector that every pipeline register consumes. It also sequences multi-cycle EX operations with an internal countdown, so EX only raises a one-cycle start pulse. It keeps stall performance counters for debug.

## Interface
Parameters:
- `MC_LEN_W`, default 6: width of the multi-cycle length field.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in, 1: the single clock.
- `rst` in, 1: synchronous, active-high reset.
- `stallreq_id` in, 1: load-use hazard request from ID. Level, combinational from ID.
- `ex_mc_start` in, 1: one-cycle pulse when a multi-cycle op enters EX.
- `ex_mc_len` in, MC_LEN_W: total EX occupancy in cycles, valid with `ex_mc_start`.
- `stallreq_mem` in, 1: data SRAM wait. Level.
- `stall` out, `StallBus` (6): bit0 PC, bit1 IF/ID reg, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB. Each bit is `Stop`/`NoStop`.
- `mc_busy` out, 1: a multi-cycle op is in progress.
- `mc_done` out, 1: registered one-cycle pulse. EX latches the result in this cycle.
- `stall_cycles` out, CNT_W: number of cycles with `stall[0]` = Stop.
- `loaduse_cnt` out, CNT_W: number of cycles in which the load-use pattern was the winning source.

## Operation
- Stall patterns:
  - Load-use (LU) = 6'b000111.
  - Multi-cycle (MC) = 6'b001111.
  - Memory wait (MW) = 6'b011111.
- `stall` = bitwise OR of all active patterns. The pattern is always a contiguous run of Stop from bit0. The highest source (MW > MC > LU) determines the result.
- The bubble rule stays in the stage registers: a stage whose bit is Stop while the next stage's bit is NoStop inserts a bubble. That means ID inserts a bubble for LU, EX for MC, and MEM for MW.
- FSM states:
  - RUN: idle. `ex_mc_start` with `ex_mc_len` ≥ 2 loads `cnt` = `ex_mc_len` − 1 and moves to MC. MC pattern is asserted combinationally in the start cycle. `ex_mc_len` ∈ {0,1} requests no stall and causes no state change; `mc_done` pulses next cycle only if len = 1.
  - MC: MC pattern is asserted while `cnt` > 1. `cnt` decrements every cycle regardless of MW; the unit runs independently. When `cnt` = 1, the MC pattern is asserted for that final cycle, then the FSM returns to RUN and `mc_done` is set for the following cycle.
  - `ex_mc_start` in MC is ignored. This is illegal: EX is frozen; the bench flags it.
- Net effect: MC stall is active for exactly `ex_mc_len` cycles starting with the start cycle. `mc_done` is high in the first cycle after the last stall cycle.
- If MW is still asserted when MC ends, `stall` keeps the MW pattern. `mc_done` still pulses, and EX must hold the result until its stall bit clears.
- LU during MC or MW is masked. Its pattern is a subset, and `loaduse_cnt` does not increment.
- Counters wrap at 2^CNT_W without saturation.
- `mc_busy` = (state == MC).

## Timing
- Reset values: state RUN, `cnt` 0, `stall` 0, `mc_busy` 0, `mc_done` 0, both counters 0.
- Reset during MC aborts the op immediately. No `mc_done` is produced.
- `stall` is combinational from inputs and state, with zero latency from `stallreq_id` and `stallreq_mem`. There is no combinational path from `stall` back to any input.
- `mc_busy` and `mc_done` are registered outputs.
- Counters update on the clock edge that ends the counted cycle and are visible one cycle later.
- Simultaneous `ex_mc_start` + `stallreq_mem` in RUN: the op is accepted and `stall` = MW.

## Structure
- The `StallBus` width, `Stop`/`NoStop`, and the LU/MC/MW pattern constants belong in the shared `lib/defines.vh`.
- FSM state encodings are local parameters.
- One sub-module fits naturally: `mc_counter`, which loads `ex_mc_len`−1, decrements, and flags the last cycle.

## Test plan
- Single load-use: `stallreq_id` high for 1 cycle in RUN → `stall` = 6'b000111 that cycle, 0 next; `loaduse_cnt` = 1, `stall_cycles` = 1.
- Divide: `ex_mc_start`, len = 33 (width 6 holds up to 63) → MC pattern for exactly 33 cycles, `mc_busy` high for 32 cycles, `mc_done` pulse at cycle 34, `stall_cycles` = 33.
- len = 1 and len = 0: len = 1 → no stall, `mc_done` next cycle; len = 0 → no stall, no `mc_done`.
- Overlap: len = 5 start, `stallreq_mem` high in cycles 3–7 → `stall` = 001111 for cycles 1–2, 011111 for cycles 3–7, 0 at cycle 8; `mc_done` at cycle 6.
- LU masked: `stallreq_id` high during MC → `stall` = 001111 and `loaduse_cnt` unchanged.
- Reset mid-op: `rst` asserted in cycle 3 of a len = 10 op → next cycle all outputs 0 and state RUN; no `mc_done` ever appears.
